// File: rtl/psum_acc.sv
// psum_acc: partial-sum accumulator bank that sums signed MAC-column words into
// depth entries with saturation, then streams all entries out on a drain request.
// Optional feature: define PSUM_ACC_RELU_EN to clamp negative entries to 0 on output.
module psum_acc #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 16,
    parameter int unsigned addr_bw = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [psum_bw-1:0] in_data,
    input  logic        [addr_bw-1:0] in_addr,
    input  logic                      in_first,
    input  logic                      drain,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [psum_bw-1:0] out_data,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned SUM_W = psum_bw + 1;
    localparam logic        [addr_bw-1:0] LAST_ADDR = addr_bw'(depth - 1);
    localparam logic signed [psum_bw-1:0] PSUM_MAX  = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] PSUM_MIN  = {1'b1, {(psum_bw-1){1'b0}}};

    // Signed add with clamping to the representable partial-sum range.
    function automatic logic signed [psum_bw-1:0] sat_add(
        input logic signed [psum_bw-1:0] a,
        input logic signed [psum_bw-1:0] b
    );
        logic [SUM_W-1:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[SUM_W-1] != s[SUM_W-2]) begin
            return s[SUM_W-1] ? PSUM_MIN : PSUM_MAX;
        end
        return s[psum_bw-1:0];
    endfunction

    // Output view of an entry; stored entries are never altered by this.
    function automatic logic signed [psum_bw-1:0] present(
        input logic signed [psum_bw-1:0] v
    );
`ifdef PSUM_ACC_RELU_EN
        return v[psum_bw-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    state_t                    state_q, state_d;
    logic signed [psum_bw-1:0] mem_q [depth];
    logic signed [psum_bw-1:0] mem_d [depth];
    logic        [addr_bw-1:0] rd_ptr_q, rd_ptr_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [psum_bw-1:0] out_data_q, out_data_d;
    logic                      done_q, done_d;
    logic                      in_ready_q, in_ready_d;
    logic                      in_fire;
    logic        [addr_bw-1:0] rd_next;

    assign in_fire   = in_valid && in_ready_q;
    assign rd_next   = rd_ptr_q + addr_bw'(1);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

    // Next-state, accumulate-write and drain-stream logic.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE, ACC: begin
                // A word accepted in the drain-request cycle lands before draining starts.
                if (in_fire) begin
                    mem_d[in_addr] = in_first ? in_data : sat_add(mem_q[in_addr], in_data);
                    state_d        = ACC;
                end
                if (drain) begin
                    state_d  = DRAIN;
                    rd_ptr_d = '0;
                end
            end
            DRAIN: begin
                // out_valid is low only in the first drain cycle: load entry 0.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = present(mem_q[rd_ptr_q]);
                end else if (out_ready) begin
                    mem_d[rd_ptr_q] = '0;
                    if (rd_ptr_q == LAST_ADDR) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        done_d      = 1'b1;
                        rd_ptr_d    = '0;
                        state_d     = IDLE;
                    end else begin
                        rd_ptr_d    = rd_next;
                        out_data_d  = present(mem_q[rd_next]);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d != DRAIN);
    end

    // State and output registers; reset discards all entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule
